muldiv_arbiter: RTL and testbench

Shared iterative multiply/divide service for the multi-core byte unit. It arbitrates round-robin between NUM_REQ CPU execute stages and runs one 16-cycle shift-add multiply or restoring divide at a time. It returns the result to the granted requester with a one-cycle pulse. Each execute stage holds its phase open until that pulse arrives.

---
 rtl/muldiv_pkg.sv | 19 +
 rtl/muldiv_engine.sv | 94 +++++++++
 rtl/muldiv_arbiter.sv | 145 ++++++++++++++
 tb/tb_muldiv_arbiter.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/muldiv_pkg.sv
// rtl/muldiv_pkg.sv - shared types and defaults for the multiply/divide arbiter
package muldiv_pkg;

    // Operation selector, matches the per-requester req_op bit.
    typedef enum logic {
        OP_MUL = 1'b0,
        OP_DIV = 1'b1
    } muldiv_op_t;

    // Arbiter control states.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } muldiv_state_t;

    localparam int DEF_DATA_W = 16;

endpackage

// File: rtl/muldiv_engine.sv
// rtl/muldiv_engine.sv - iterative shift-add multiplier / restoring divider
//
// Ports:
//   clk, rstn     clock, synchronous active-low reset
//   start         latch op/a/b and begin DATA_W iterations
//   op, a, b      operation and operands (A = multiplicand/dividend, B = multiplier/divisor)
//   done          high during the final iteration cycle
//   result        low product bits (MUL) or quotient (DIV); stable after done
//   dbz           DIV with B == 0
module muldiv_engine
    import muldiv_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              start,
    input  muldiv_op_t        op,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic              done,
    output logic [DATA_W-1:0] result,
    output logic              dbz
);

    localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DATA_W - 1);

    logic              r_run;
    logic [CNT_W-1:0]  r_cnt;
    muldiv_op_t        r_op;
    logic [DATA_W-1:0] r_a;
    logic [DATA_W-1:0] r_b;
    logic [DATA_W-1:0] r_acc;
    logic [DATA_W-1:0] r_rem;
    logic [DATA_W-1:0] r_q;

    logic [CNT_W-1:0]  w_bit_idx;
    logic [DATA_W-1:0] w_addend;
    logic [DATA_W:0]   w_rem_sh;
    logic              w_ge;
    logic [DATA_W-1:0] w_rem_sub;

    // Divider walks A from the MSB while the multiplier walks B from the LSB.
    assign w_bit_idx = LAST_CNT - r_cnt;
    assign w_addend  = r_b[r_cnt] ? (r_a << r_cnt) : '0;
    assign w_rem_sh  = {r_rem, r_a[w_bit_idx]};
    assign w_ge      = (w_rem_sh >= {1'b0, r_b});
    // When w_ge holds the true difference is below B, so the low bits suffice.
    assign w_rem_sub = w_rem_sh[DATA_W-1:0] - r_b;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_run <= 1'b0;
            r_cnt <= '0;
            r_op  <= OP_MUL;
            r_a   <= '0;
            r_b   <= '0;
            r_acc <= '0;
            r_rem <= '0;
            r_q   <= '0;
        end else if (start) begin
            r_run <= 1'b1;
            r_cnt <= '0;
            r_op  <= op;
            r_a   <= a;
            r_b   <= b;
            r_acc <= '0;
            r_rem <= '0;
            r_q   <= '0;
        end else if (r_run) begin
            if (r_op == OP_MUL) begin
                r_acc <= r_acc + w_addend;
            end else begin
                // B == 0 always takes this branch, giving an all-ones quotient.
                if (w_ge) begin
                    r_rem          <= w_rem_sub;
                    r_q[w_bit_idx] <= 1'b1;
                end else begin
                    r_rem <= w_rem_sh[DATA_W-1:0];
                end
            end
            r_cnt <= r_cnt + 1'b1;
            if (r_cnt == LAST_CNT) begin
                r_run <= 1'b0;
            end
        end
    end

    assign done   = r_run && (r_cnt == LAST_CNT);
    assign result = (r_op == OP_DIV) ? r_q : r_acc;
    assign dbz    = (r_op == OP_DIV) && (r_b == '0);

endmodule

// File: rtl/muldiv_arbiter.sv
// rtl/muldiv_arbiter.sv - round-robin arbiter in front of a shared multiply/divide engine
//
// Ports:
//   clk, rstn        clock, synchronous active-low reset
//   req_valid        per-requester request
//   req_op           per-requester op (0 = MUL, 1 = DIV)
//   req_a, req_b     packed operands, requester i at [i*DATA_W +: DATA_W]
//   req_ready        one-hot grant, combinational, only in IDLE
//   rsp_valid        one-hot one-cycle result pulse to the owner
//   rsp_result       result, meaningful while rsp_valid is non-zero
//   rsp_div_by_zero  DIV with B == 0, alongside rsp_valid
//   busy             high whenever not IDLE
module muldiv_arbiter
    import muldiv_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int DATA_W  = DEF_DATA_W
) (
    input  logic                      clk,
    input  logic                      rstn,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ-1:0]        req_op,
    input  logic [NUM_REQ*DATA_W-1:0] req_a,
    input  logic [NUM_REQ*DATA_W-1:0] req_b,
    output logic [NUM_REQ-1:0]        req_ready,
    output logic [NUM_REQ-1:0]        rsp_valid,
    output logic [DATA_W-1:0]         rsp_result,
    output logic                      rsp_div_by_zero,
    output logic                      busy
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_REQ - 1);

    muldiv_state_t     r_state;
    muldiv_state_t     w_state_nxt;
    logic [IDX_W-1:0]  r_last_grant;
    logic [IDX_W-1:0]  r_owner;

    logic [IDX_W-1:0]  w_cand;
    logic [IDX_W-1:0]  w_gidx;
    logic              w_any;
    logic              w_start;
    muldiv_op_t        w_op;
    logic [DATA_W-1:0] w_a;
    logic [DATA_W-1:0] w_b;
    logic              w_eng_done;
    logic [DATA_W-1:0] w_eng_result;
    logic              w_eng_dbz;

    function automatic logic [IDX_W-1:0] rr_next(input logic [IDX_W-1:0] idx);
        return (idx == LAST_IDX) ? '0 : idx + 1'b1;
    endfunction

    // Walk last_grant+1, +2, ... and take the first valid requester.
    always_comb begin
        w_any  = 1'b0;
        w_gidx = r_last_grant;
        w_cand = r_last_grant;
        for (int k = 0; k < NUM_REQ; k++) begin
            w_cand = rr_next(w_cand);
            if (!w_any && req_valid[w_cand]) begin
                w_any  = 1'b1;
                w_gidx = w_cand;
            end
        end
    end

    assign w_op = muldiv_op_t'(req_op[w_gidx]);
    assign w_a  = req_a[w_gidx*DATA_W +: DATA_W];
    assign w_b  = req_b[w_gidx*DATA_W +: DATA_W];

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_state      <= IDLE;
            r_last_grant <= LAST_IDX;
            r_owner      <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_start) begin
                r_last_grant <= w_gidx;
                r_owner      <= w_gidx;
            end
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_start         = 1'b0;
        req_ready       = '0;
        rsp_valid       = '0;
        rsp_result      = '0;
        rsp_div_by_zero = 1'b0;
        busy            = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_any) begin
                    w_start           = 1'b1;
                    req_ready[w_gidx] = 1'b1;
                    w_state_nxt       = RUN;
                end
            end
            RUN: begin
                busy = 1'b1;
                if (w_eng_done) begin
                    w_state_nxt = DONE;
                end
            end
            DONE: begin
                busy               = 1'b1;
                rsp_valid[r_owner] = 1'b1;
                rsp_result         = w_eng_result;
                rsp_div_by_zero    = w_eng_dbz;
                w_state_nxt        = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
        // Outputs are held at their reset values for as long as rstn is low.
        if (!rstn) begin
            w_start         = 1'b0;
            req_ready       = '0;
            rsp_valid       = '0;
            rsp_result      = '0;
            rsp_div_by_zero = 1'b0;
            busy            = 1'b0;
        end
    end

    muldiv_engine #(
        .DATA_W (DATA_W)
    ) u_engine (
        .clk    (clk),
        .rstn   (rstn),
        .start  (w_start),
        .op     (w_op),
        .a      (w_a),
        .b      (w_b),
        .done   (w_eng_done),
        .result (w_eng_result),
        .dbz    (w_eng_dbz)
    );

endmodule

// File: tb/tb_muldiv_arbiter.sv
// tb/tb_muldiv_arbiter.sv - self-checking bench for muldiv_arbiter
module tb_muldiv_arbiter;

    localparam int NR  = 2;
    localparam int DW  = 16;
    localparam int LAT = DW + 1;   // accept edge to the response cycle

    logic             clk = 1'b0;
    logic             rstn;
    logic [NR-1:0]    req_valid;
    logic [NR-1:0]    req_op;
    logic [NR*DW-1:0] req_a;
    logic [NR*DW-1:0] req_b;
    logic [NR-1:0]    req_ready;
    logic [NR-1:0]    rsp_valid;
    logic [DW-1:0]    rsp_result;
    logic             rsp_div_by_zero;
    logic             busy;

    always #5 clk = ~clk;

    muldiv_arbiter #(.NUM_REQ(NR), .DATA_W(DW)) dut (
        .clk             (clk),
        .rstn            (rstn),
        .req_valid       (req_valid),
        .req_op          (req_op),
        .req_a           (req_a),
        .req_b           (req_b),
        .req_ready       (req_ready),
        .rsp_valid       (rsp_valid),
        .rsp_result      (rsp_result),
        .rsp_div_by_zero (rsp_div_by_zero),
        .busy            (busy)
    );

    int n_checks = 0;
    int n_errors = 0;

    typedef enum {RQ_IDLE, RQ_WAIT, RQ_FLIGHT} rq_t;
    rq_t           st   [NR];
    bit            opd  [NR];
    logic [DW-1:0] opa  [NR];
    logic [DW-1:0] opb  [NR];

    // Transaction-level model of the shared unit.
    bit            m_free;
    int            m_age;
    int            m_owner;
    int            m_last;
    logic [DW-1:0] m_res;
    bit            m_dbz;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [DW-1:0] ref_calc(input bit is_div, input logic [DW-1:0] a,
                                               input logic [DW-1:0] b);
        logic [2*DW-1:0] p;
        if (!is_div) begin
            p = {{DW{1'b0}}, a} * {{DW{1'b0}}, b};
            return p[DW-1:0];
        end
        if (b == 0) return '1;
        return a / b;
    endfunction

    function automatic logic [DW-1:0] rnd_operand();
        case ($urandom_range(0, 7))
            0:       return '0;
            1:       return '1;
            2:       return DW'($urandom_range(1, 15));
            default: return DW'($urandom);
        endcase
    endfunction

    function automatic bit all_idle();
        for (int r = 0; r < NR; r++) if (st[r] != RQ_IDLE) return 1'b0;
        return 1'b1;
    endfunction

    task automatic model_reset();
        m_free = 1'b1;
        m_age  = 0;
        m_last = NR - 1;
        for (int r = 0; r < NR; r++) if (st[r] == RQ_FLIGHT) st[r] = RQ_IDLE;
    endtask

    task automatic raise(input int r, input bit is_div, input logic [DW-1:0] a, input logic [DW-1:0] b);
        st[r]  = RQ_WAIT;
        opd[r] = is_div;
        opa[r] = a;
        opb[r] = b;
        req_valid[r]        = 1'b1;
        req_op[r]           = is_div;
        req_a[r*DW +: DW]   = a;
        req_b[r*DW +: DW]   = b;
    endtask

    task automatic withdraw(input int r);
        st[r]        = RQ_IDLE;
        req_valid[r] = 1'b0;
    endtask

    // Advance one clock; the model follows the edge that just happened.
    task automatic tick();
        @(posedge clk);
        #1;
        if (rstn !== 1'b1) begin
            model_reset();
        end else if (!m_free) begin
            m_age++;
            if (m_age > LAT) m_free = 1'b1;
        end
        for (int r = 0; r < NR; r++) if (st[r] == RQ_FLIGHT) req_valid[r] = 1'b0;
    endtask

    // Compare the DUT against the model for the current cycle.
    task automatic check_cycle();
        logic [NR-1:0] exp_ready;
        logic [NR-1:0] exp_rsp;
        int win;
        int cand;
        #1;
        exp_ready = '0;
        exp_rsp   = '0;
        if (rstn !== 1'b1) begin
            check("rst_ready", req_ready, 0);
            check("rst_rsp_valid", rsp_valid, 0);
            check("rst_rsp_result", rsp_result, 0);
            check("rst_dbz", rsp_div_by_zero, 0);
            check("rst_busy", busy, 0);
            return;
        end
        check("busy", busy, !m_free);
        if (m_free) begin
            win = -1;
            for (int k = 1; k <= NR; k++) begin
                cand = (m_last + k) % NR;
                if (win < 0 && st[cand] == RQ_WAIT) win = cand;
            end
            if (win >= 0) exp_ready[win] = 1'b1;
            check("req_ready", req_ready, exp_ready);
            check("rsp_valid_idle", rsp_valid, 0);
            if (win >= 0) begin
                m_free  = 1'b0;
                m_age   = 0;
                m_owner = win;
                m_last  = win;
                m_res   = ref_calc(opd[win], opa[win], opb[win]);
                m_dbz   = opd[win] && (opb[win] == 0);
                st[win] = RQ_FLIGHT;
            end
        end else begin
            check("req_ready_busy", req_ready, 0);
            if (m_age == LAT) begin
                exp_rsp[m_owner] = 1'b1;
                check("rsp_valid", rsp_valid, exp_rsp);
                check("rsp_result", rsp_result, m_res);
                check("rsp_dbz", rsp_div_by_zero, m_dbz);
                if (st[m_owner] == RQ_FLIGHT) st[m_owner] = RQ_IDLE;
            end else begin
                check("rsp_valid_quiet", rsp_valid, 0);
            end
        end
    endtask

    task automatic drain();
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            tick();
            check_cycle();
            if (m_free && all_idle()) begin
                ok = 1'b1;
                break;
            end
        end
        check("drain_timeout", ok, 1);
    endtask

    task automatic do_reset();
        rstn = 1'b0;
        tick();
        check_cycle();
        tick();
        rstn = 1'b1;
    endtask

    initial begin
        rstn      = 1'b0;
        req_valid = '0;
        req_op    = '0;
        req_a     = '0;
        req_b     = '0;
        for (int r = 0; r < NR; r++) st[r] = RQ_IDLE;
        model_reset();

        // Reset with a request already pending: outputs stay at reset values.
        raise(0, 1'b0, 16'h0007, 16'h0006);
        do_reset();
        check_cycle();
        drain();

        // Directed arithmetic cases.
        tick(); raise(1, 1'b1, 16'd100,  16'd7);    check_cycle(); drain();
        tick(); raise(0, 1'b0, 16'h1234, 16'h0100); check_cycle(); drain();
        tick(); raise(1, 1'b1, 16'hFFFF, 16'h0001); check_cycle(); drain();
        tick(); raise(0, 1'b1, 16'h0055, 16'h0000); check_cycle(); drain();

        // Fairness: both ask together after reset, each re-requests on its own response.
        do_reset();
        raise(0, 1'b0, rnd_operand(), rnd_operand());
        raise(1, 1'b1, rnd_operand(), rnd_operand());
        check_cycle();
        for (int i = 0; i < 4 * (LAT + 1); i++) begin
            tick();
            if (!m_free && m_age == LAT)
                raise(m_owner, 1'($urandom_range(0, 1)), rnd_operand(), rnd_operand());
            check_cycle();
        end
        for (int r = 0; r < NR; r++) if (st[r] == RQ_WAIT) withdraw(r);
        drain();

        // Reset in the middle of a run; the pending req1 must not win over req0.
        tick(); raise(0, 1'b0, rnd_operand(), rnd_operand()); check_cycle();
        for (int i = 1; i < 8; i++) begin
            tick();
            if (i == 3) raise(1, 1'b1, rnd_operand(), rnd_operand());
            check_cycle();
        end
        tick();
        rstn = 1'b0;
        check_cycle();
        tick();
        rstn = 1'b1;
        raise(0, 1'b1, rnd_operand(), rnd_operand());
        check_cycle();
        drain();

        // Withdrawal during RUN: no grant, FSM stays idle.
        tick(); raise(0, 1'b0, rnd_operand(), rnd_operand()); check_cycle();
        for (int i = 0; i < LAT + 4; i++) begin
            tick();
            if (!m_free && m_age == 5)  raise(1, 1'b0, rnd_operand(), rnd_operand());
            if (!m_free && m_age == 12) withdraw(1);
            check_cycle();
        end
        drain();

        // Random traffic with withdrawals and same-cycle re-requests.
        for (int i = 0; i < 2000; i++) begin
            tick();
            for (int r = 0; r < NR; r++) begin
                if (st[r] == RQ_IDLE && $urandom_range(0, 3) == 0)
                    raise(r, 1'($urandom_range(0, 1)), rnd_operand(), rnd_operand());
                else if (st[r] == RQ_WAIT && $urandom_range(0, 31) == 0)
                    withdraw(r);
                else if (st[r] == RQ_FLIGHT && !m_free && m_age == LAT && m_owner == r
                         && $urandom_range(0, 1) == 1)
                    raise(r, 1'($urandom_range(0, 1)), rnd_operand(), rnd_operand());
            end
            check_cycle();
        end
        for (int r = 0; r < NR; r++) if (st[r] == RQ_WAIT) withdraw(r);
        drain();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
